// File: rtl/rr_response_router_if.sv
// Handshake bundle between the PLM scheduler return path and the router:
// kernel grant tags, PLM read data, and per-consumer valid/ready responses.
interface rr_response_router_if #(
  parameter int VALUE_WIDTH = 8,
  parameter int NCONSUMERS  = 2,
  parameter int NBANKS      = 1,
  parameter int NPORTS      = 1
);
  localparam int NKERNELS = NBANKS * NPORTS;
  localparam int CID_W =
    (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1;

  logic [NKERNELS-1:0]                  grant_valid;
  logic [NKERNELS-1:0][CID_W-1:0]       grant_cid;
  logic [NKERNELS-1:0][VALUE_WIDTH-1:0] plm_rdata;

  logic [NCONSUMERS-1:0]                  resp_valid;
  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] resp_data;
  logic [NCONSUMERS-1:0]                  resp_ready;

  modport master (
    output grant_valid,
    output grant_cid,
    output plm_rdata,
    output resp_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  grant_valid,
    input  grant_cid,
    input  plm_rdata,
    input  resp_ready,
    output resp_valid,
    output resp_data
  );
endinterface

// File: rtl/rr_response_router.sv
// Routes PLM read data from each kernel back to the consumer owning the read.
// Ports: clk, reset (sync, active-high), bus (slave side of the
// rr_response_router_if), collision_err and overflow_err (sticky flags).
module rr_response_router #(
  parameter int VALUE_WIDTH = 8,
  parameter int NCONSUMERS  = 2,
  parameter int NBANKS      = 1,
  parameter int NPORTS      = 1,
  parameter int MEM_LATENCY = 1,
  parameter int RESP_DEPTH  = 4
) (
  input  logic clk,
  input  logic reset,
  rr_response_router_if.slave bus,
  output logic collision_err,
  output logic overflow_err
);
  localparam int NKERNELS = NBANKS * NPORTS;
  localparam int CID_W =
    (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1;
  localparam int AW = $clog2(RESP_DEPTH);
  localparam int LAST = MEM_LATENCY - 1;

  localparam logic [CID_W:0] NCONS =
    (CID_W+1)'(NCONSUMERS);
  localparam logic [AW:0] FULLCNT =
    (AW+1)'(RESP_DEPTH);

  typedef logic [VALUE_WIDTH-1:0] word_t;
  typedef logic [CID_W-1:0]       cid_t;
  typedef logic [AW-1:0]          ptr_t;
  typedef logic [AW:0]            cnt_t;

  // Tag pipelines: one {valid,cid} shift chain per kernel,
  // the last stage lines up with plm_rdata.
  logic [MEM_LATENCY-1:0] tag_v [NKERNELS];
  cid_t tag_c [NKERNELS][MEM_LATENCY];

  always_ff @(posedge clk) begin
    for (int k = 0; k < NKERNELS; k++) begin
      tag_c[k][0] <= bus.grant_cid[k];
      for (int s = 1; s < MEM_LATENCY; s++) begin
        tag_c[k][s] <= tag_c[k][s-1];
      end
    end
    if (reset) begin
      for (int k = 0; k < NKERNELS; k++) begin
        tag_v[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NKERNELS; k++) begin
        tag_v[k][0] <= bus.grant_valid[k];
        for (int s = 1; s < MEM_LATENCY; s++) begin
          tag_v[k][s] <= tag_v[k][s-1];
        end
      end
    end
  end

  // Return steering. Lowest kernel wins a consumer; any
  // loser or out-of-range cid is a collision.
  logic [NCONSUMERS-1:0] push_v;
  word_t                 push_d [NCONSUMERS];
  logic                  coll;

  always_comb begin
    push_v = '0;
    coll   = 1'b0;
    for (int c = 0; c < NCONSUMERS; c++) begin
      push_d[c] = '0;
    end
    for (int k = 0; k < NKERNELS; k++) begin
      if (tag_v[k][LAST]) begin
        if ({1'b0, tag_c[k][LAST]} >= NCONS) begin
          coll = 1'b1;
        end else if (push_v[tag_c[k][LAST]]) begin
          coll = 1'b1;
        end else begin
          push_v[tag_c[k][LAST]] = 1'b1;
          push_d[tag_c[k][LAST]] = bus.plm_rdata[k];
        end
      end
    end
  end

  // Per-consumer FWFT response FIFOs.
  word_t mem [NCONSUMERS][RESP_DEPTH];
  ptr_t  wp  [NCONSUMERS];
  ptr_t  rp  [NCONSUMERS];
  cnt_t  cnt [NCONSUMERS];

  logic [NCONSUMERS-1:0] nonempty;
  logic [NCONSUMERS-1:0] full;
  logic [NCONSUMERS-1:0] pop;
  logic [NCONSUMERS-1:0] acc;
  logic [NCONSUMERS-1:0] ovf;

  always_comb begin
    for (int c = 0; c < NCONSUMERS; c++) begin
      nonempty[c] = (cnt[c] != '0);
      full[c]     = (cnt[c] == FULLCNT);
      pop[c]      = nonempty[c] & bus.resp_ready[c];
      // A full FIFO can still take a push if it pops
      // in the same cycle.
      acc[c]      = push_v[c] & (~full[c] | pop[c]);
      ovf[c]      = push_v[c] & full[c] & ~pop[c];
    end
  end

  always_comb begin
    for (int c = 0; c < NCONSUMERS; c++) begin
      bus.resp_valid[c] = nonempty[c];
      bus.resp_data[c]  =
        nonempty[c] ? mem[c][rp[c]] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NCONSUMERS; c++) begin
        wp[c]  <= '0;
        rp[c]  <= '0;
        cnt[c] <= '0;
      end
      collision_err <= 1'b0;
      overflow_err  <= 1'b0;
    end else begin
      for (int c = 0; c < NCONSUMERS; c++) begin
        if (acc[c]) begin
          mem[c][wp[c]] <= push_d[c];
          wp[c]         <= wp[c] + 1'b1;
        end
        if (pop[c]) begin
          rp[c] <= rp[c] + 1'b1;
        end
        case ({acc[c], pop[c]})
          2'b10:   cnt[c] <= cnt[c] + 1'b1;
          2'b01:   cnt[c] <= cnt[c] - 1'b1;
          default: cnt[c] <= cnt[c];
        endcase
      end
      if (coll) begin
        collision_err <= 1'b1;
      end
      if (|ovf) begin
        overflow_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rr_response_router.sv
// Directed bench for rr_response_router: a 2-kernel, latency-1
// instance (ua) and a 1-kernel, latency-3 instance (ub).
module tb_rr_response_router;
  logic clk = 1'b0;
  logic ra  = 1'b1;
  logic rb  = 1'b1;
  logic ca, oa, cb, ob;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rr_response_router_if #(
    .VALUE_WIDTH(8), .NCONSUMERS(2),
    .NBANKS(2), .NPORTS(1)
  ) ia ();

  rr_response_router_if #(
    .VALUE_WIDTH(8), .NCONSUMERS(2),
    .NBANKS(1), .NPORTS(1)
  ) ib ();

  rr_response_router #(
    .VALUE_WIDTH(8), .NCONSUMERS(2), .NBANKS(2),
    .NPORTS(1), .MEM_LATENCY(1), .RESP_DEPTH(4)
  ) ua (
    .clk(clk), .reset(ra), .bus(ia.slave),
    .collision_err(ca), .overflow_err(oa)
  );

  rr_response_router #(
    .VALUE_WIDTH(8), .NCONSUMERS(2), .NBANKS(1),
    .NPORTS(1), .MEM_LATENCY(3), .RESP_DEPTH(4)
  ) ub (
    .clk(clk), .reset(rb), .bus(ib.slave),
    .collision_err(cb), .overflow_err(ob)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Grant on kernel k for consumer c, return d one cycle later.
  task automatic issue_a(input int k, input logic c,
                         input logic [7:0] d);
    ia.grant_valid    = '0;
    ia.grant_valid[k] = 1'b1;
    ia.grant_cid[k]   = c;
    step();
    ia.grant_valid  = '0;
    ia.plm_rdata[k] = d;
    step();
    ia.plm_rdata[k] = '0;
  endtask

  task automatic drain1(input string tag,
                        input logic [7:0] first,
                        input int n);
    ia.resp_ready[1] = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_v"}, 32'(ia.resp_valid[1]), 32'd1);
      chk({tag, "_d"}, 32'(ia.resp_data[1]),
          32'(first) + 32'(i));
      step();
    end
    ia.resp_ready[1] = 1'b0;
    chk({tag, "_empty"}, 32'(ia.resp_valid[1]), 32'd0);
  endtask

  initial begin
    ia.grant_valid = '0;
    ia.grant_cid   = '0;
    ia.plm_rdata   = '0;
    ia.resp_ready  = '0;
    ib.grant_valid = '0;
    ib.grant_cid   = '0;
    ib.plm_rdata   = '0;
    ib.resp_ready  = '0;

    step();
    step();
    ra = 1'b0;
    step();
    chk("rst_valid", 32'(ia.resp_valid), 32'd0);
    chk("rst_data", 32'(ia.resp_data), 32'd0);
    chk("rst_coll", 32'(ca), 32'd0);
    chk("rst_ovf", 32'(oa), 32'd0);

    // Single read k0 -> cid1, data A5.
    ia.grant_valid[0] = 1'b1;
    ia.grant_cid[0]   = 1'b1;
    step();
    ia.grant_valid  = '0;
    ia.plm_rdata[0] = 8'hA5;
    step();
    ia.plm_rdata[0] = '0;
    chk("a5_valid", 32'(ia.resp_valid), 32'h2);
    chk("a5_data1", 32'(ia.resp_data[1]), 32'hA5);
    chk("a5_data0", 32'(ia.resp_data[0]), 32'h0);
    ia.resp_ready[0] = 1'b1;
    step();
    ia.resp_ready[0] = 1'b0;
    chk("a5_hold", 32'(ia.resp_data[1]), 32'hA5);
    ia.resp_ready[1] = 1'b1;
    step();
    ia.resp_ready[1] = 1'b0;
    chk("a5_popped", 32'(ia.resp_valid), 32'h0);

    // Fill 1..4 with ready low, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      issue_a(0, 1'b1, 8'(i));
    end
    drain1("fill", 8'd1, 4);
    chk("fill_ovf", 32'(oa), 32'd0);

    // Full FIFO with same-cycle push and pop.
    for (int i = 6; i <= 9; i++) begin
      issue_a(0, 1'b1, 8'(i));
    end
    ia.grant_valid[0] = 1'b1;
    ia.grant_cid[0]   = 1'b1;
    step();
    ia.grant_valid   = '0;
    ia.plm_rdata[0]  = 8'd10;
    ia.resp_ready[1] = 1'b1;
    step();
    ia.plm_rdata[0]  = '0;
    ia.resp_ready[1] = 1'b0;
    chk("pp_ovf", 32'(oa), 32'd0);
    drain1("pp", 8'd7, 4);

    // Overflow: fifth push to a full FIFO is dropped.
    for (int i = 1; i <= 5; i++) begin
      issue_a(0, 1'b1, 8'(i));
    end
    chk("ovf_set", 32'(oa), 32'd1);
    step();
    chk("ovf_held", 32'(oa), 32'd1);
    drain1("ovf", 8'd1, 4);
    chk("ovf_sticky", 32'(oa), 32'd1);
    chk("ovf_nocoll", 32'(ca), 32'd0);

    // Collision: k0 and k1 both return to cid0.
    ia.grant_valid = 2'b11;
    ia.grant_cid   = '0;
    step();
    ia.grant_valid  = '0;
    ia.plm_rdata[0] = 8'h11;
    ia.plm_rdata[1] = 8'h22;
    step();
    ia.plm_rdata = '0;
    chk("coll_valid", 32'(ia.resp_valid), 32'h1);
    chk("coll_data", 32'(ia.resp_data[0]), 32'h11);
    chk("coll_err", 32'(ca), 32'd1);
    ia.resp_ready[0] = 1'b1;
    step();
    ia.resp_ready[0] = 1'b0;
    chk("coll_only1", 32'(ia.resp_valid), 32'h0);
    chk("coll_sticky", 32'(ca), 32'd1);

    // Latency-3 instance: reset with two reads in flight.
    rb = 1'b0;
    step();
    ib.grant_valid[0] = 1'b1;
    ib.grant_cid[0]   = 1'b0;
    step();
    ib.grant_cid[0] = 1'b1;
    step();
    ib.grant_valid = '0;
    rb = 1'b1;
    step();
    rb = 1'b0;
    ib.plm_rdata[0] = 8'h77;
    for (int i = 0; i < 5; i++) begin
      chk("flush_valid", 32'(ib.resp_valid), 32'd0);
      step();
    end
    chk("flush_coll", 32'(cb), 32'd0);
    chk("flush_ovf", 32'(ob), 32'd0);

    // Latency-3 instance: grant->valid is 4 cycles.
    ib.grant_valid[0] = 1'b1;
    ib.grant_cid[0]   = 1'b0;
    ib.plm_rdata[0]   = 8'h5A;
    step();
    ib.grant_valid = '0;
    step();
    step();
    chk("lat3_early", 32'(ib.resp_valid), 32'd0);
    step();
    chk("lat3_valid", 32'(ib.resp_valid), 32'h1);
    chk("lat3_data", 32'(ib.resp_data[0]), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
